// File: rtl/bit_stream_feeder_pkg.sv
// Shared encodings for the bit stream feeder and the lab 5 sequence-detector top.
package bit_stream_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } feeder_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/bit_stream_feeder_key_debounce.sv
// Pushbutton conditioning: 2-FF synchroniser, stability counter, one-cycle press pulse.
module key_debounce
    import bit_stream_feeder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Press is the released-to-pressed edge of the accepted level.
        pulse_d = level_q & ~level_d;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/bit_stream_feeder.sv
// Captures a switch pattern and emits it LSB first, one bit per debounced button press.
module bit_stream_feeder
    import bit_stream_feeder_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int LEN_W           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [LEN_W-1:0] length,
    input  logic             step_n,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] bits_left
);

    feeder_state_t    state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0] bits_left_q, bits_left_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             step_pulse;
    logic [LEN_W-1:0] eff_len;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clock      (clock),
        .resetn     (resetn),
        .key_n      (step_n),
        .press_pulse(step_pulse)
    );

    // Zero or oversized lengths mean "the whole register".
    assign eff_len = ((length == '0) || (length > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : length;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        if (load) begin
            shreg_d     = pattern_in;
            bits_left_d = eff_len;
            state_d     = ST_ARMED;
        end else if (state_q == ST_ARMED && step_pulse && bits_left_q != '0) begin
            bit_out_d   = shreg_q[0];
            shreg_d     = shreg_q >> 1;
            bits_left_d = bits_left_q - 1'b1;
            bit_valid_d = 1'b1;
            if (bits_left_q == LEN_W'(1)) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bits_left_q <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign bits_left = bits_left_q;
    assign busy      = (state_q == ST_ARMED);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_bit_stream_feeder.sv
// Directed bench for bit_stream_feeder with a short debounce window.
module tb_bit_stream_feeder;
    import bit_stream_feeder_pkg::*;

    localparam int W  = 8;
    localparam int LW = 4;
    localparam int DC = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  pattern_in = '0;
    logic [LW-1:0] length = '0;
    logic          step_n = 1'b1;
    logic          bit_out, bit_valid, busy, done;
    logic [LW-1:0] bits_left;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int cyc = 0;
    int valid_cyc = 0;
    logic prev_valid = 1'b0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic [W-1:0]  pat;
        logic [LW-1:0] len;
        int            exp_len;
    } vec_t;
    vec_t vecs[5];

    bit_stream_feeder #(.WIDTH(W), .LEN_W(LW), .DEBOUNCE_CYCLES(DC)) dut (
        .clock(clock), .resetn(resetn), .load(load), .pattern_in(pattern_in),
        .length(length), .step_n(step_n), .bit_out(bit_out), .bit_valid(bit_valid),
        .busy(busy), .done(done), .bits_left(bits_left)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Strobe monitor: records each emitted bit and flags back-to-back strobes.
    always @(negedge clock) begin
        if (bit_valid) begin
            vcount <= vcount + 1;
            valid_cyc <= cyc;
            if (exp_q.size() > 0) begin
                check("stream_bit", int'(bit_out), int'(exp_q.pop_front()));
            end
            check("no_back_to_back", int'(prev_valid), 0);
        end
        prev_valid <= bit_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] p, input logic [LW-1:0] l);
        tick(1);
        load = 1'b1; pattern_in = p; length = l;
        tick(1);
        load = 1'b0;
    endtask

    task automatic press();
        step_n = 1'b0;
        tick(10);
        step_n = 1'b1;
        tick(10);
    endtask

    task automatic check_idle(input string name);
        check({name, "_bit_out"}, int'(bit_out), 0);
        check({name, "_bit_valid"}, int'(bit_valid), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_bits_left"}, int'(bits_left), 0);
        check({name, "_state"}, int'(dut.state_q), int'(ST_IDLE));
    endtask

    initial begin
        int v0, c0;
        vecs[0] = '{8'b0000_1011, 4'd4, 4};
        vecs[1] = '{8'hA5, 4'd0, 8};
        vecs[2] = '{8'hA5, 4'd12, 8};
        vecs[3] = '{8'h3C, 4'd3, 3};
        vecs[4] = '{8'h96, 4'd8, 8};

        // Reset held with the button chattering.
        for (int i = 0; i < 3; i++) begin
            step_n = ~step_n;
            tick(1);
            check("reset_valid", int'(bit_valid), 0);
            check("reset_bits_left", int'(bits_left), 0);
        end
        step_n = 1'b1;
        resetn = 1'b1;
        tick(DC + 4);
        check_idle("after_reset");
        v0 = vcount;
        press();
        check("idle_press_ignored", vcount - v0, 0);

        // Table-driven streams.
        for (int t = 0; t < 5; t++) begin
            do_load(vecs[t].pat, vecs[t].len);
            check("load_bits_left", int'(bits_left), vecs[t].exp_len);
            check("load_busy", int'(busy), 1);
            for (int i = 0; i < vecs[t].exp_len; i++) begin
                exp_q.push_back(vecs[t].pat[i]);
                v0 = vcount;
                press();
                check("one_strobe", vcount - v0, 1);
                check("bit_out_hold", int'(bit_out), int'(vecs[t].pat[i]));
                check("bits_left_step", int'(bits_left), vecs[t].exp_len - 1 - i);
            end
            check("end_done", int'(done), 1);
            check("end_busy", int'(busy), 0);
            v0 = vcount;
            press();
            check("done_press_ignored", vcount - v0, 0);
            check("done_bits_left", int'(bits_left), 0);
        end

        // Bounce rejection then one clean hold.
        do_load(8'hFF, 4'd8);
        v0 = vcount;
        for (int i = 0; i < 3; i++) begin
            step_n = 1'b0; tick(2);
            step_n = 1'b1; tick(2);
        end
        check("glitch_no_strobe", vcount - v0, 0);
        exp_q.push_back(1'b1);
        step_n = 1'b0;
        c0 = cyc;
        tick(10);
        step_n = 1'b1;
        tick(10);
        check("bounce_one_strobe", vcount - v0, 1);
        check("bounce_latency", valid_cyc - c0, 7);
        check("bounce_bits_left", int'(bits_left), 7);

        // Load colliding with a step pulse.
        do_load(8'h03, 4'd5);
        exp_q.push_back(1'b1); press();
        exp_q.push_back(1'b1); press();
        check("pre_collide_bits_left", int'(bits_left), 3);
        v0 = vcount;
        step_n = 1'b0;
        tick(6);
        load = 1'b1; pattern_in = 8'h02; length = 4'd6;
        tick(1);
        load = 1'b0;
        tick(2);
        check("collide_no_strobe", vcount - v0, 0);
        check("collide_bits_left", int'(bits_left), 6);
        check("collide_bit_out", int'(bit_out), 1);
        step_n = 1'b1;
        tick(10);
        exp_q.push_back(1'b0);
        press();
        check("collide_new_pattern", int'(bit_out), 0);
        check("collide_after_bits_left", int'(bits_left), 5);

        // Load held high keeps re-capturing.
        tick(1);
        load = 1'b1; pattern_in = 8'h0F; length = 4'd2;
        tick(2);
        pattern_in = 8'h01; length = 4'd7;
        tick(1);
        load = 1'b0;
        check("held_load_bits_left", int'(bits_left), 7);
        check("held_load_busy", int'(busy), 1);
        exp_q.push_back(1'b1);
        press();
        check("held_load_first_bit", int'(bit_out), 1);

        // Reset mid-stream.
        do_load(8'h15, 4'd5);
        exp_q.push_back(1'b1); press();
        exp_q.push_back(1'b0); press();
        check("mid_bits_left", int'(bits_left), 3);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        check_idle("mid_reset");
        v0 = vcount;
        press();
        press();
        check("post_reset_no_strobe", vcount - v0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/bit_stream_feeder.md
Name: bit_stream_feeder

Overview:
Upstream stimulus stage for the lab 5 sequence-detector FSM. It captures a pattern of up to WIDTH bits from the switches. Each debounced press of a pushbutton then emits one bit, LSB first, together with a one-cycle strobe. bit_out drives the detector's w input and bit_valid drives its clock enable, so a recognised sequence is stepped through one bit per press without switch bounce.

Parameters:
WIDTH, 8, maximum pattern length in bits.
LEN_W, 4, width of the length field; must hold values 0..WIDTH.
DEBOUNCE_CYCLES, 500000, number of consecutive stable clock cycles before a button level is accepted (10 ms at 50 MHz).

Ports:
clock  in  1  system clock, rising edge (CLOCK_50 on the board).
resetn  in  1  synchronous, active-low reset.
load  in  1  level; sampled every cycle; captures pattern_in and length.
pattern_in  in  WIDTH  pattern to emit; bit 0 goes out first.
length  in  LEN_W  number of bits to emit.
step_n  in  1  raw pushbutton, active low, asynchronous, bouncy.
bit_out  out  1  current stream bit; holds the last emitted value between strobes.
bit_valid  out  1  one-cycle strobe; bit_out is new in this cycle.
busy  out  1  high in ARMED.
done  out  1  high in DONE.
bits_left  out  LEN_W  bits remaining to emit.

Behaviour:
- Reset: resetn sampled on the clock edge, synchronous, active-low.
  - All outputs go to 0 and state goes to IDLE.
  - Shift register is cleared.
  - Synchroniser flops and debounced level go to 1 (button released).
  - Debounce counter goes to 0.
  - Reset applied mid-stream aborts the stream; no strobe is produced in that cycle.
- Input conditioning:
  - 2-FF synchroniser on step_n.
  - Debounce counter clears whenever the synced level equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - step_pulse is high for exactly one cycle on a 1->0 transition of the debounced level.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- Latency: a clean press produces step_pulse 2+DEBOUNCE_CYCLES cycles after the step_n edge. bit_valid is registered and rises 1 cycle after step_pulse.
- FSM states: IDLE, ARMED, DONE.
  - Any state, load=1:
    - shreg <= pattern_in.
    - bits_left <= eff_len, where eff_len = WIDTH if length==0 or length>WIDTH, else length.
    - Next state ARMED.
    - bit_out is unchanged and bit_valid=0.
    - load has priority: a step_pulse in the same cycle is discarded.
  - IDLE: step_pulse is ignored.
  - ARMED, step_pulse, load=0:
    - bit_out <= shreg[0]; shreg <= shreg >> 1 (zero fill).
    - bits_left <= bits_left-1; bit_valid <= 1.
    - If bits_left==1 before the step, next state is DONE; otherwise stay in ARMED.
  - DONE: done=1 is held. step_pulse is ignored (no strobe, bits_left stays 0). load re-arms.
- load held high for several cycles re-captures every cycle and stays in ARMED with a full count. Emission starts only after load falls.
- bit_valid is never high in two consecutive cycles.
- bits_left never wraps below 0.

Decomposition:
- Shared package: state encoding localparams (IDLE=2'd0, ARMED=2'd1, DONE=2'd2) and the default DEBOUNCE_CYCLES constant. The sequence-detector lab top and the test bench reuse these.
- One sub-module, key_debounce. It contains the synchroniser, debounce counter and falling-edge detector. Ports: clock, resetn, key_n, press_pulse. Parameter: DEBOUNCE_CYCLES.

Test Plan (DEBOUNCE_CYCLES=4 for all):
- Reset: hold resetn=0 for 3 cycles with step_n toggling -> all outputs 0, no bit_valid; after release, state IDLE.
- Basic stream:
  - Stimulus: load pattern_in=8'b0000_1011, length=4, then 4 clean presses.
  - Required: bit_out sequence 1,1,0,1 with one bit_valid each; bits_left 4->3->2->1->0.
  - After the last bit: done=1, busy=0. A 5th press gives no strobe.
- Bounce rejection: step_n pulses low for 2 cycles, 3 times, then stays low for 10 cycles -> exactly one bit_valid, occurring 7 cycles after the final falling edge.
- Length clamp: length=0 and length=12 with pattern_in=8'hA5 -> bits_left=8; 8 presses emit 1,0,1,0,0,1,0,1.
- Load/step collision: in ARMED with bits_left=3, assert load in the same cycle as step_pulse -> no bit_valid; bits_left reloads to the new length; bit_out is unchanged.
- Reset mid-stream: after 2 of 5 bits, pulse resetn low for 1 cycle -> outputs 0, IDLE; subsequent presses give no strobe until the next load.
